// File: rtl/shift_left_right_deserializer_if.sv
// Serial receive link bundle: bit strobes in, framed words out through a
// one-entry valid/ready holding buffer.
interface shift_left_right_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             serial_in;
  logic             bit_valid;
  logic             shift_left_right;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;

  modport master (
    output serial_in, bit_valid, shift_left_right, clear, q_ready,
    input  q, q_valid, bit_count, overrun
  );

  modport slave (
    input  serial_in, bit_valid, shift_left_right, clear, q_ready,
    output q, q_valid, bit_count, overrun
  );
endinterface

// File: rtl/shift_left_right_deserializer.sv
// Serial-in/parallel-out receiver: frames WIDTH strobed bits (MSB- or LSB-first)
// into words and hands them to a one-entry holding buffer with overrun detection.
module shift_left_right_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  shift_left_right_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] bit_count;
  logic             dir;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             overrun_r;

  logic             dir_eff;
  logic [WIDTH-1:0] sr_next;
  logic             word_done;
  logic             pop;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             d,
                                                input logic             b);
    if (d) shift_in = {b, cur[WIDTH-1:1]};
    else   shift_in = {cur[WIDTH-2:0], b};
  endfunction

  // The first bit of a word takes the live direction; later bits use the latched one.
  always_comb begin
    dir_eff   = (state == IDLE) ? bus.shift_left_right : dir;
    sr_next   = shift_in(sr, dir_eff, bus.serial_in);
    word_done = bus.bit_valid && !bus.clear && (state == COLLECT) &&
                (bit_count == CNT_W'(WIDTH - 1));
    pop       = q_valid_r && bus.q_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      bit_count <= '0;
      dir       <= 1'b0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (bus.clear) begin
        state     <= IDLE;
        bit_count <= '0;
        overrun_r <= 1'b0;
      end else if (bus.bit_valid) begin
        sr <= sr_next;
        case (state)
          IDLE: begin
            dir       <= bus.shift_left_right;
            bit_count <= CNT_W'(1);
            state     <= COLLECT;
          end
          COLLECT: begin
            if (word_done) begin
              bit_count <= '0;
              state     <= IDLE;
            end else begin
              bit_count <= bit_count + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A pop in the same cycle frees the slot for the completing word.
      if (word_done) begin
        if (!q_valid_r || pop) begin
          q_r       <= sr_next;
          q_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (pop) begin
        q_valid_r <= 1'b0;
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.q_valid   = q_valid_r;
  assign bus.bit_count = bit_count;
  assign bus.overrun   = overrun_r;
endmodule
